// File: rtl/sched_datapath_ctrl.sv
// Resource-shared signed compare/select/shift kernel.
// One add/sub unit and one comparator, sequenced over seven states per job.
module sched_datapath_ctrl #(
  parameter int unsigned WIDTH     = 64,
  parameter int unsigned OUT_WIDTH = 32
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 Start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [WIDTH-1:0]     c,
  output logic [OUT_WIDTH-1:0] x,
  output logic [OUT_WIDTH-1:0] z,
  output logic                 Done,
  output logic                 Busy
);

  typedef enum logic [2:0] {
    WAIT  = 3'd0,
    S1    = 3'd1,
    S2    = 3'd2,
    S3    = 3'd3,
    S4    = 3'd4,
    S5    = 3'd5,
    FINAL = 3'd6
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [WIDTH-1:0]     r_ra, r_rb, r_rc;
  logic [WIDTH-1:0]     r_d, r_e, r_f, r_g, r_h;
  logic                 r_dlte, r_deq;
  logic [OUT_WIDTH-1:0] r_x, r_z;
  logic                 r_done, r_busy;

  logic [WIDTH-1:0]     w_addend;
  logic                 w_sub;
  logic [WIDTH-1:0]     w_sum;
  logic                 w_lt, w_eq;
  logic [WIDTH-1:0]     w_sel;

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= WAIT;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      WAIT:    if (Start) w_next = S1;
      S1:      w_next = S2;
      S2:      w_next = S3;
      S3:      w_next = S4;
      S4:      w_next = S5;
      S5:      w_next = FINAL;
      FINAL:   w_next = WAIT;
      default: w_next = WAIT;
    endcase
  end

  // Single shared add/sub: S2 adds rc, S3 subtracts rb, otherwise adds rb
  always_comb begin
    w_addend = (r_state == S2) ? r_rc : r_rb;
    w_sub    = (r_state == S3);
    w_sum    = r_ra + (w_sub ? ~w_addend : w_addend) + WIDTH'(w_sub);
  end

  // Comparator and select feeding the S4 updates
  always_comb begin
    w_lt  = ($signed(r_d) < $signed(r_e));
    w_eq  = (r_d == r_e);
    w_sel = w_lt ? r_e : r_d;
  end

  // Datapath registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_ra   <= '0;
      r_rb   <= '0;
      r_rc   <= '0;
      r_d    <= '0;
      r_e    <= '0;
      r_f    <= '0;
      r_g    <= '0;
      r_h    <= '0;
      r_dlte <= 1'b0;
      r_deq  <= 1'b0;
      r_x    <= '0;
      r_z    <= '0;
    end else begin
      case (r_state)
        WAIT: begin
          if (Start) begin
            r_ra <= a;
            r_rb <= b;
            r_rc <= c;
          end
        end
        S1: r_d <= w_sum;
        S2: r_e <= w_sum;
        S3: r_f <= w_sum;
        S4: begin
          r_dlte <= w_lt;
          r_deq  <= w_eq;
          r_g    <= w_sel;
          r_h    <= w_eq ? r_f : w_sel;
        end
        S5: begin
          r_x <= OUT_WIDTH'(r_h << r_dlte);
          r_z <= OUT_WIDTH'($signed(r_g) >>> r_deq);
        end
        default: ;
      endcase
    end
  end

  // Handshake flags track the state being entered, so they align with the state
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_done <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      r_done <= (w_next == FINAL);
      r_busy <= (w_next != WAIT);
    end
  end

  assign x    = r_x;
  assign z    = r_z;
  assign Done = r_done;
  assign Busy = r_busy;

endmodule

// File: tb/tb_sched_datapath_ctrl.sv
// Directed bench for sched_datapath_ctrl: hand-computed job results,
// mid-job reset, ignored Start while busy, and continuous back-to-back jobs.
module tb_sched_datapath_ctrl;

  logic        CLK;
  logic        RST;
  logic        Start;
  logic [63:0] a, b, c;
  logic [31:0] x, z;
  logic        Done, Busy;

  int n_checks = 0;
  int n_fail   = 0;

  sched_datapath_ctrl #(.WIDTH(64), .OUT_WIDTH(32)) dut (
    .CLK(CLK), .RST(RST), .Start(Start),
    .a(a), .b(b), .c(c),
    .x(x), .z(z), .Done(Done), .Busy(Busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference kernel used only for the streaming test
  function automatic logic [63:0] kernel(input logic [63:0] ka, input logic [63:0] kb,
                                         input logic [63:0] kc);
    logic signed [63:0] d, e, f, g, h, zs;
    logic lt, eq;
    logic [63:0] xs;
    d  = ka + kb;
    e  = ka + kc;
    f  = ka - kb;
    lt = d < e;
    eq = d == e;
    g  = lt ? e : d;
    h  = eq ? f : g;
    xs = lt ? (h << 1) : h;
    zs = eq ? (g >>> 1) : g;
    return {xs[31:0], zs[31:0]};
  endfunction

  function automatic logic [63:0] va(input int j);
    return (j % 3 == 0) ? -64'(j * 17) : 64'(j * 29 + 1);
  endfunction
  function automatic logic [63:0] vb(input int j);
    return 64'(j * 5) - 64'd20;
  endfunction
  function automatic logic [63:0] vc(input int j);
    return 64'd40 - 64'(j * 3);
  endfunction

  // One job; Start is re-pulsed and operands scrambled while busy
  task automatic run_job(input string tag, input logic [63:0] ta, input logic [63:0] tb_v,
                         input logic [63:0] tc, input logic [31:0] ex, input logic [31:0] ez);
    int   lat;
    logic seen;
    @(negedge CLK);
    a = ta; b = tb_v; c = tc; Start = 1'b1;
    @(posedge CLK);
    lat = 0;
    do begin
      @(negedge CLK);
      lat++;
      seen  = Done;
      Start = (lat == 2);
      a = ~ta; b = ta; c = ~tc;
    end while (!seen && lat < 20);
    Start = 1'b0;
    check({tag, "_lat"}, 64'(lat), 64'd6);
    check({tag, "_x"}, 64'(x), 64'(ex));
    check({tag, "_z"}, 64'(z), 64'(ez));
    @(negedge CLK);
    check({tag, "_done_low"}, 64'(Done), 64'd0);
    check({tag, "_idle"}, 64'(Busy), 64'd0);
    check({tag, "_xhold"}, 64'(x), 64'(ex));
  endtask

  initial begin
    logic [63:0] m;
    logic [31:0] hx, hz;
    int ndone;
    bit  exp_done;

    RST = 1'b1; Start = 1'b0; a = '0; b = '0; c = '0;
    @(negedge CLK);
    @(negedge CLK);
    check("rst_x", 64'(x), 64'd0);
    check("rst_z", 64'(z), 64'd0);
    check("rst_done", 64'(Done), 64'd0);
    check("rst_busy", 64'(Busy), 64'd0);
    RST = 1'b0;

    run_job("t2", 64'd5, 64'd3, 64'd10, 32'h0000001E, 32'h0000000F);

    // Reset while in S3 clears outputs immediately
    @(negedge CLK);
    a = 64'd7; b = 64'd2; c = 64'd1; Start = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    Start = 1'b0;
    check("t1_busy_s1", 64'(Busy), 64'd1);
    @(posedge CLK);
    @(posedge CLK);
    #2 RST = 1'b1;
    #1;
    check("t1_rst_x", 64'(x), 64'd0);
    check("t1_rst_z", 64'(z), 64'd0);
    check("t1_rst_done", 64'(Done), 64'd0);
    check("t1_rst_busy", 64'(Busy), 64'd0);
    @(negedge CLK);
    RST = 1'b0;
    run_job("t1_after", 64'd5, 64'd3, 64'd10, 32'h0000001E, 32'h0000000F);

    run_job("t3a", 64'd4, 64'd6, 64'd6, 32'hFFFFFFFE, 32'h00000005);
    run_job("t3b", 64'd1, 64'd9, 64'd2, 32'h0000000A, 32'h0000000A);
    run_job("t4", -64'sd8, -64'sd8, 64'd0, 32'hFFFFFFF0, 32'hFFFFFFF8);
    run_job("t5", 64'h7FFFFFFFFFFFFFFF, 64'd1, 64'd0, 32'hFFFFFFFE, 32'hFFFFFFFF);

    // Start held high with operands changing every cycle
    hx = 32'hFFFFFFFE; hz = 32'hFFFFFFFF; ndone = 0;
    for (int j = 0; j < 28; j++) begin
      a = va(j); b = vb(j); c = vc(j); Start = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      exp_done = (j >= 5) && ((j - 5) % 7 == 0);
      check($sformatf("t6_done_%0d", j), 64'(Done), 64'(exp_done));
      if (Done) ndone++;
      if (exp_done) begin
        m  = kernel(va(j - 5), vb(j - 5), vc(j - 5));
        hx = m[63:32];
        hz = m[31:0];
      end
      check($sformatf("t6_x_%0d", j), 64'(x), 64'(hx));
      check($sformatf("t6_z_%0d", j), 64'(z), 64'(hz));
    end
    Start = 1'b0;
    check("t6_ndone", 64'(ndone), 64'd4);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
